// File: rtl/ram_arb_pkg.sv
// Shared types, defaults and helpers for the RAM write-port arbiter.
package ram_arb_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    localparam int DEF_AW = 12;
    localparam int DEF_DW = 8;

    // Index of the lowest set bit; returns 0 when no bit is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_arb_grant.sv
// One-hot grant generator: round-robin when RAM_ARB_RR_EN is defined,
// fixed priority (lowest index wins) otherwise.
module ram_arb_grant
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] grant
);

    logic [2:0] sel;
    logic       has;

`ifdef RAM_ARB_RR_EN
    logic [2:0] ptr_reg;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        idx = 0;
        has = 1'b0;
        sel = ptr_reg;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_reg) + k) % NREQ;
            if (!has && req_valid[idx]) begin
                has = 1'b1;
                sel = 3'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= 3'(NREQ - 1);
        end else if (en && has) begin
            ptr_reg <= sel;
        end
    end
`else
    assign has = |req_valid;
    assign sel = lowest_set(8'(req_valid));

    logic unused_ok;
    assign unused_ok = ^{clk, rst};
`endif

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
            assign grant[gi] = en && has && (sel == 3'(gi));
        end
    endgenerate

endmodule

// File: rtl/ram_wr_arbiter.sv
// Shares the RAM write port between NREQ writers and a full-RAM fill engine.
// Optional round-robin arbitration is enabled by defining RAM_ARB_RR_EN.
module ram_wr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               fill_start,
    input  logic [DW-1:0]      fill_data,
    output logic               fill_busy,
    output logic               fill_done,
    output logic               wreq,
    output logic [AW-1:0]      waddr,
    output logic [DW-1:0]      wdata
);

    state_t          state_reg, state_next;
    logic [AW-1:0]   cnt_reg;
    logic [DW-1:0]   fill_val_reg;
    logic            arb_en;
    logic            cnt_last;
    logic [NREQ-1:0] grant;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    assign cnt_last  = &cnt_reg;
    assign req_ready = grant;

    ram_arb_grant #(
        .NREQ(NREQ)
    ) u_grant (
        .clk      (clk),
        .rst      (rst),
        .en       (arb_en),
        .req_valid(req_valid),
        .grant    (grant)
    );

    // Grant is one-hot, so an AND-OR mux picks the winner's address/data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr |= req_addr[i*AW +: AW];
                sel_data |= req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_ARB;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ARB:  if (fill_start) state_next = ST_FILL;
            ST_FILL: if (cnt_last)   state_next = ST_ARB;
            default: state_next = ST_ARB;
        endcase
    end

    always_comb begin
        arb_en    = (state_reg == ST_ARB);
        fill_busy = (state_reg == ST_FILL);
    end

    // A request granted in the same cycle as fill_start is written first;
    // the sweep then starts on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wreq         <= 1'b0;
            waddr        <= '0;
            wdata        <= '0;
            fill_done    <= 1'b0;
            cnt_reg      <= '0;
            fill_val_reg <= '0;
        end else if (state_reg == ST_FILL) begin
            wreq      <= 1'b1;
            waddr     <= cnt_reg;
            wdata     <= fill_val_reg;
            fill_done <= cnt_last;
            cnt_reg   <= cnt_reg + 1'b1;
        end else begin
            fill_done <= 1'b0;
            wreq      <= |grant;
            if (|grant) begin
                waddr <= sel_addr;
                wdata <= sel_data;
            end
            if (fill_start) begin
                fill_val_reg <= fill_data;
                cnt_reg      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Directed self-checking bench for ram_wr_arbiter (NREQ=2, AW=12, DW=8).
module tb_ram_wr_arbiter;

    localparam int NREQ  = 2;
    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               fill_start;
    logic [DW-1:0]      fill_data;
    logic               fill_busy;
    logic               fill_done;
    logic               wreq;
    logic [AW-1:0]      waddr;
    logic [DW-1:0]      wdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ram_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .fill_start(fill_start),
        .fill_data (fill_data),
        .fill_busy (fill_busy),
        .fill_done (fill_done),
        .wreq      (wreq),
        .waddr     (waddr),
        .wdata     (wdata)
    );

    task automatic test_reset;
        #1;
        total_cnt++;
        if ({wreq, waddr, wdata, fill_busy, fill_done} !== '0)
            $display("FAIL reset_outputs: got wreq=%b waddr=%h wdata=%h busy=%b done=%b, want all 0",
                     wreq, waddr, wdata, fill_busy, fill_done);
        else pass_cnt++;
        total_cnt++;
        if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b want 00", req_ready);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single;
        @(negedge clk);
        req_valid = 2'b01;
        req_addr  = {12'h000, 12'h123};
        req_data  = {8'h00, 8'h5A};
        #1;
        total_cnt++;
        if (req_ready !== 2'b01) $display("FAIL single_ready: got %b want 01", req_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({wreq, waddr, wdata} !== {1'b1, 12'h123, 8'h5A})
            $display("FAIL single_write: got wreq=%b waddr=%h wdata=%h want 1/123/5a", wreq, waddr, wdata);
        else pass_cnt++;
        req_valid = 2'b00;
        @(negedge clk);
        total_cnt++;
        if ({wreq, waddr, wdata} !== {1'b0, 12'h123, 8'h5A})
            $display("FAIL single_idle: got wreq=%b waddr=%h wdata=%h want 0/123/5a (held)", wreq, waddr, wdata);
        else pass_cnt++;
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        req_valid = 2'b01;
        req_addr  = {12'h000, 12'h3C3};
        req_data  = {8'h00, 8'h99};
        @(posedge clk);
        #2;
        req_valid = 2'b00;
        total_cnt++;
        if ({wreq, waddr, wdata} !== {1'b1, 12'h3C3, 8'h99})
            $display("FAIL pre_reset_write: got wreq=%b waddr=%h wdata=%h want 1/3c3/99", wreq, waddr, wdata);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({wreq, waddr, wdata, fill_busy, fill_done} !== '0)
            $display("FAIL async_reset: got wreq=%b waddr=%h wdata=%h busy=%b done=%b, want all 0",
                     wreq, waddr, wdata, fill_busy, fill_done);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [NREQ-1:0] exp_rdy [6];
        logic [AW-1:0]   exp_addr;
`ifdef RAM_ARB_RR_EN
        exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_rdy = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
        @(negedge clk);
        req_addr  = {12'h200, 12'h100};
        req_data  = {8'h22, 8'h11};
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            total_cnt++;
            if (req_ready !== exp_rdy[i]) $display("FAIL b2b_ready[%0d]: got %b want %b", i, req_ready, exp_rdy[i]);
            else pass_cnt++;
            exp_addr = (exp_rdy[i] == 2'b01) ? 12'h100 : 12'h200;
            @(negedge clk);
            total_cnt++;
            if ({wreq, waddr} !== {1'b1, exp_addr})
                $display("FAIL b2b_write[%0d]: got wreq=%b waddr=%h want 1/%h", i, wreq, waddr, exp_addr);
            else pass_cnt++;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_fill;
        int bad;
        int rdy_bad;
        logic [DW-1:0] exp_fill;
        bad = 0;
        rdy_bad = 0;
        exp_fill = 8'hA5;
        @(negedge clk);
        req_addr   = {12'h000, 12'h0AB};
        req_data   = {8'h00, 8'hCD};
        fill_data  = 8'hA5;
        fill_start = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        req_valid  = 2'b01;
        #1;
        total_cnt++;
        if ({fill_busy, req_ready} !== {1'b1, 2'b00})
            $display("FAIL fill_enter: got busy=%b ready=%b want 1/00", fill_busy, req_ready);
        else pass_cnt++;
        for (int j = 0; j < DEPTH; j++) begin
            if (j == 10)  fill_data = 8'h3C;
            if (j == 100) fill_start = 1'b1;
            if (j == 101) fill_start = 1'b0;
            @(negedge clk);
            if (wreq !== 1'b1 || waddr !== AW'(j) || wdata !== exp_fill ||
                fill_done !== (j == DEPTH - 1) || fill_busy !== (j != DEPTH - 1)) begin
                if (bad == 0)
                    $display("FAIL fill_seq[%0d]: got wreq=%b waddr=%h wdata=%h done=%b busy=%b want 1/%h/%h/%b/%b",
                             j, wreq, waddr, wdata, fill_done, fill_busy, AW'(j), exp_fill,
                             (j == DEPTH - 1), (j != DEPTH - 1));
                bad++;
            end
            if (req_ready !== ((j == DEPTH - 1) ? 2'b01 : 2'b00)) rdy_bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL fill_seq_total: got %0d bad cycles want 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (rdy_bad != 0) $display("FAIL fill_ready: got %0d bad cycles want 0", rdy_bad);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({wreq, waddr, wdata, fill_done} !== {1'b1, 12'h0AB, 8'hCD, 1'b0})
            $display("FAIL post_fill_grant: got wreq=%b waddr=%h wdata=%h done=%b want 1/0ab/cd/0",
                     wreq, waddr, wdata, fill_done);
        else pass_cnt++;
        req_valid = 2'b00;
        @(negedge clk);
        total_cnt++;
        if ({fill_busy, wreq} !== 2'b00)
            $display("FAIL second_start_ignored: got busy=%b wreq=%b want 0/0", fill_busy, wreq);
        else pass_cnt++;
    endtask

    task automatic test_fill_with_req;
        int bad;
        bad = 0;
        @(negedge clk);
        req_valid  = 2'b10;
        req_addr   = {12'h010, 12'h000};
        req_data   = {8'h77, 8'h00};
        fill_data  = 8'h00;
        fill_start = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 2'b10) $display("FAIL fwr_ready: got %b want 10", req_ready);
        else pass_cnt++;
        @(negedge clk);
        fill_start = 1'b0;
        req_valid  = 2'b00;
        total_cnt++;
        if ({wreq, waddr, wdata, fill_busy} !== {1'b1, 12'h010, 8'h77, 1'b1})
            $display("FAIL fwr_first: got wreq=%b waddr=%h wdata=%h busy=%b want 1/010/77/1",
                     wreq, waddr, wdata, fill_busy);
        else pass_cnt++;
        for (int j = 0; j < DEPTH; j++) begin
            @(negedge clk);
            if (wreq !== 1'b1 || waddr !== AW'(j) || wdata !== 8'h00 || fill_done !== (j == DEPTH - 1)) begin
                if (bad == 0)
                    $display("FAIL fwr_seq[%0d]: got wreq=%b waddr=%h wdata=%h done=%b want 1/%h/00/%b",
                             j, wreq, waddr, wdata, fill_done, AW'(j), (j == DEPTH - 1));
                bad++;
            end
        end
        total_cnt++;
        if (bad != 0) $display("FAIL fwr_seq_total: got %0d bad cycles want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_fill;
        int seen_done;
        seen_done = 0;
        @(negedge clk);
        fill_data  = 8'hFF;
        fill_start = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        for (int j = 0; j <= 12'h800; j++) @(negedge clk);
        total_cnt++;
        if ({wreq, waddr, fill_busy} !== {1'b1, 12'h800, 1'b1})
            $display("FAIL mid_fill_pos: got wreq=%b waddr=%h busy=%b want 1/800/1", wreq, waddr, fill_busy);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({wreq, waddr, wdata, fill_busy, fill_done} !== '0)
            $display("FAIL mid_fill_reset: got wreq=%b waddr=%h wdata=%h busy=%b done=%b want all 0",
                     wreq, waddr, wdata, fill_busy, fill_done);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (fill_done !== 1'b0 || fill_busy !== 1'b0) seen_done++;
        end
        total_cnt++;
        if (seen_done != 0) $display("FAIL no_resume: got %0d cycles busy/done want 0", seen_done);
        else pass_cnt++;
        req_valid = 2'b01;
        req_addr  = {12'h000, 12'h055};
        req_data  = {8'h00, 8'h11};
        #1;
        total_cnt++;
        if (req_ready !== 2'b01) $display("FAIL post_reset_ready: got %b want 01", req_ready);
        else pass_cnt++;
        @(negedge clk);
        req_valid = 2'b00;
        total_cnt++;
        if ({wreq, waddr, wdata} !== {1'b1, 12'h055, 8'h11})
            $display("FAIL post_reset_write: got wreq=%b waddr=%h wdata=%h want 1/055/11", wreq, waddr, wdata);
        else pass_cnt++;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_addr   = '0;
        req_data   = '0;
        fill_start = 1'b0;
        fill_data  = '0;
        test_reset;
        test_single;
        test_async_reset;
        test_back_to_back;
        test_fill;
        test_fill_with_req;
        test_reset_mid_fill;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
